// File: rtl/three_way_arbiter.sv
// three_way_arbiter: sticky fixed-priority 3-way arbiter; define ARBITER_FAST_HANDOFF_EN for direct owner-to-owner handoff
module three_way_arbiter (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] r,
  output logic [2:0] g
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1, GNT2} state_t;
  state_t state, pick, next;
  logic hold;
  // Highest-priority pending requester, consulted only at a decision point
  always_comb pick = r[0] ? GNT0 : r[1] ? GNT1 : r[2] ? GNT2 : IDLE;
  // Current owner keeps the grant while it still requests; otherwise decide or fall back to idle
  always_comb begin
    hold = |(r & g);
`ifdef ARBITER_FAST_HANDOFF_EN
    next = hold ? state : pick;
`else
    next = hold ? state : state == IDLE ? pick : IDLE;
`endif
  end
  // State and one-hot grant are registered together so g never depends combinationally on r
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state <= IDLE;
      g <= '0;
    end else begin
      state <= next;
      g <= {next == GNT2, next == GNT1, next == GNT0};
    end
endmodule

// File: tb/tb_three_way_arbiter.sv
// tb_three_way_arbiter: directed and random checks of three_way_arbiter against an owner-based model
module tb_three_way_arbiter;
  logic clk = 0;
  logic resetn = 0;
  logic [2:0] r = 3'b111;
  logic [2:0] g;
  int checks = 0;
  int errors = 0;
  int owner = -1;
  three_way_arbiter dut (.clk(clk), .resetn(resetn), .r(r), .g(g));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", tag, act, exp);
    end
  endtask
  function automatic int first_req(input logic [2:0] v);
    for (int i = 0; i < 3; i++) if (v[i]) return i;
    return -1;
  endfunction
  task automatic step(input logic [2:0] rv);
    logic [2:0] want;
    r = rv;
    @(posedge clk);
    if (owner >= 0 && rv[owner]) owner = owner;
    else if (owner < 0) owner = first_req(rv);
`ifdef ARBITER_FAST_HANDOFF_EN
    else owner = first_req(rv);
`else
    else owner = -1;
`endif
    #1;
    want = owner < 0 ? 3'b000 : 3'(1 << owner);
    chk("model", g, want);
    chk("onehot", {2'b00, $countones(g) <= 1}, 3'b001);
    chk("cause", g & ~rv, 3'b000);
  endtask
  initial begin
    logic [2:0] pats [6] = '{3'b110, 3'b101, 3'b100, 3'b011, 3'b010, 3'b001};
    logic [2:0] exps [6] = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001};
    #1 chk("reset_async", g, 3'b000);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1 chk("reset_hold", g, 3'b000);
    end
    resetn = 1;
    step(3'b111);
    chk("release", g, 3'b001);
    step(3'b000);
    step(3'b000);
    for (int i = 0; i < 6; i++) begin
      step(pats[i]);
      chk("priority", g, exps[i]);
      step(3'b000);
      chk("priority_drop", g, 3'b000);
    end
    step(3'b100);
    chk("nopre_grant", g, 3'b100);
    step(3'b111);
    chk("nopre_hold", g, 3'b100);
    step(3'b111);
    chk("nopre_hold2", g, 3'b100);
    step(3'b011);
`ifdef ARBITER_FAST_HANDOFF_EN
    chk("nopre_release", g, 3'b001);
`else
    chk("nopre_release", g, 3'b000);
    step(3'b011);
    chk("nopre_next", g, 3'b001);
`endif
    step(3'b000);
    step(3'b000);
    step(3'b010);
    chk("handoff_grant", g, 3'b010);
    step(3'b011);
    chk("handoff_hold", g, 3'b010);
    step(3'b001);
`ifdef ARBITER_FAST_HANDOFF_EN
    chk("handoff_direct", g, 3'b001);
`else
    chk("handoff_idle", g, 3'b000);
    step(3'b001);
    chk("handoff_next", g, 3'b001);
`endif
    step(3'b000);
    step(3'b000);
    step(3'b001);
    chk("midreset_grant", g, 3'b001);
    #2 resetn = 0;
    owner = -1;
    #1 chk("midreset_drop", g, 3'b000);
    r = 3'b000;
    @(posedge clk);
    #1 chk("midreset_held", g, 3'b000);
    resetn = 1;
    step(3'b000);
    chk("midreset_after", g, 3'b000);
    step(3'b000);
    for (int i = 0; i < 10000; i++) step(3'($urandom_range(0, 7)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
